// File: rtl/ctrl_pkg.sv
// Shared opcodes, state encoding and field slices for the control unit.
// Optional conditional jumps are enabled by defining CTRL_JZ_EN.
package ctrl_pkg;

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_LDI  = 4'h1;
  localparam logic [3:0] OPC_IN   = 4'h2;
  localparam logic [3:0] OPC_OUT  = 4'h3;
  localparam logic [3:0] OPC_JMP  = 4'h4;
  localparam logic [3:0] OPC_JZ   = 4'h5;
  localparam logic [3:0] OPC_JNZ  = 4'h6;
  localparam logic [3:0] OPC_HALT = 4'h7;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_LATCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RA_MSB  = 7;
  localparam int RA_LSB  = 4;
  localparam int RB_MSB  = 3;
  localparam int RB_LSB  = 0;
  localparam int IMM_MSB = 7;

  typedef struct packed {
    logic [3:0]  a_sel;
    logic [3:0]  b_sel;
    logic [3:0]  dest_sel;
    logic [3:0]  op_sel;
    logic        data_sel;
    logic        const_sel;
    logic [15:0] const_in;
    logic        load_en;
    logic        in_ready;
    logic        out_valid;
  } ctrl_t;

  function automatic logic [3:0] opc_of(input logic [15:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Combinational decoder: instruction register and state to datapath controls.
// Handshake and write strobes only assert during EXEC.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter logic [3:0] OP_PASS_B = 4'hF
) (
  input  logic [15:0] ir_i,
  input  logic [1:0]  state_i,
  input  logic        in_valid_i,
  output ctrl_t       ctrl_o
);

  logic [3:0] opc;
  logic       exec;

  assign opc  = opc_of(ir_i);
  assign exec = (state_i == ST_EXEC);

  always_comb begin
    ctrl_o           = '0;
    ctrl_o.a_sel     = ir_i[RA_MSB:RA_LSB];
    ctrl_o.b_sel     = ir_i[RB_MSB:RB_LSB];
    ctrl_o.dest_sel  = ir_i[RD_MSB:RD_LSB];
    ctrl_o.op_sel    = {1'b0, opc[2:0]};
    unique case (1'b1)
      opc == OPC_LDI: begin
        ctrl_o.op_sel    = OP_PASS_B;
        ctrl_o.const_sel = 1'b1;
        ctrl_o.const_in  = {8'h00, ir_i[IMM_MSB:0]};
        ctrl_o.load_en   = exec;
      end
      opc == OPC_IN: begin
        ctrl_o.data_sel  = 1'b1;
        ctrl_o.in_ready  = exec;
        ctrl_o.load_en   = exec & in_valid_i;
      end
      opc == OPC_OUT: begin
        ctrl_o.out_valid = exec;
      end
      opc[3]: begin
        ctrl_o.load_en   = exec;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/latch/exec sequencer driving the 16-bit datapath controls.
// Define CTRL_JZ_EN to enable JZ/JNZ and the z_flag register.
module control_unit
  import ctrl_pkg::*;
#(
  parameter int         PC_W      = 8,
  parameter logic [3:0] OP_PASS_B = 4'hF
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic            z,
  output logic [3:0]      a_sel,
  output logic [3:0]      b_sel,
  output logic [3:0]      dest_sel,
  output logic [3:0]      op_sel,
  output logic            data_sel,
  output logic            const_sel,
  output logic [15:0]     const_in,
  output logic            load_en,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            halted
);

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc, jmp_tgt;
  logic [15:0]     ir_q, ir_d;
  logic [3:0]      opc;
  logic            take_jz, take_jnz;
  ctrl_t           ctrl;

  assign opc     = opc_of(ir_q);
  assign pc_inc  = pc_q + PC_W'(1);
  assign jmp_tgt = ir_q[PC_W-1:0];

`ifdef CTRL_JZ_EN
  logic z_flag_q, z_flag_d;

  always_comb begin
    z_flag_d = z_flag_q;
    if (state_q == ST_EXEC && (opc == OPC_LDI || opc[3]))
      z_flag_d = z;
  end

  always_ff @(posedge clk) begin
    if (rst) z_flag_q <= 1'b0;
    else     z_flag_q <= z_flag_d;
  end

  assign take_jz  = z_flag_q;
  assign take_jnz = ~z_flag_q;
`else
  logic unused_z;
  assign unused_z = z;
  assign take_jz  = 1'b0;
  assign take_jnz = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        ir_d    = imem_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        unique case (1'b1)
          opc == OPC_IN: begin
            if (!in_valid) begin
              state_d = ST_EXEC;
              pc_d    = pc_q;
            end
          end
          opc == OPC_OUT: begin
            if (!out_ready) begin
              state_d = ST_EXEC;
              pc_d    = pc_q;
            end
          end
          opc == OPC_JMP: pc_d = jmp_tgt;
          opc == OPC_JZ: begin
            if (take_jz) pc_d = jmp_tgt;
          end
          opc == OPC_JNZ: begin
            if (take_jnz) pc_d = jmp_tgt;
          end
          opc == OPC_HALT: begin
            state_d = ST_HALT;
            pc_d    = pc_q;
          end
          default: begin
          end
        endcase
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  ctrl_decode #(
    .OP_PASS_B(OP_PASS_B)
  ) u_decode (
    .ir_i       (ir_q),
    .state_i    (state_q),
    .in_valid_i (in_valid),
    .ctrl_o     (ctrl)
  );

  // Strobes are masked during reset so an aborted handshake never writes
  assign imem_addr = pc_q;
  assign a_sel     = ctrl.a_sel;
  assign b_sel     = ctrl.b_sel;
  assign dest_sel  = ctrl.dest_sel;
  assign op_sel    = ctrl.op_sel;
  assign data_sel  = ctrl.data_sel;
  assign const_sel = ctrl.const_sel;
  assign const_in  = ctrl.const_in;
  assign load_en   = ctrl.load_en & ~rst;
  assign in_ready  = ctrl.in_ready & ~rst;
  assign out_valid = ctrl.out_valid & ~rst;
  assign halted    = (state_q == ST_HALT);

endmodule
